// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_pkg
// Brief    : Shared widths, accumulator FSM state and round/saturate helpers.
// Revision : 1.0
// ============================================================================
package cnn_pkg;

  localparam int PROD_WIDTH_DEF = 22;
  localparam int OUT_WIDTH_DEF  = 14;

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_e;

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  // Half an LSB of the output format, added before the arithmetic shift.
  function automatic longint round_half(input int s);
    return longint'(1) <<< (s - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_round_sat.sv
`default_nettype none
// ============================================================================
// Module   : cnn_round_sat
// Brief    : Round-half-up rescale, optional ReLU (CNN_RELU_EN), saturate.
// Revision : 1.0
// ============================================================================
module cnn_round_sat
  import cnn_pkg::*;
#(
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
  parameter int FRAC_SHIFT = 6
) (
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  output logic signed [OUT_WIDTH-1:0] data_o,
  output logic                        sat_o
);

  localparam logic signed [ACC_WIDTH:0] c_rnd = (ACC_WIDTH+1)'(round_half(FRAC_SHIFT));
  localparam logic signed [ACC_WIDTH:0] c_max = (ACC_WIDTH+1)'(sat_max(OUT_WIDTH));
  localparam logic signed [ACC_WIDTH:0] c_min = (ACC_WIDTH+1)'(sat_min(OUT_WIDTH));

  logic signed [ACC_WIDTH:0] w_ext;
  logic signed [ACC_WIDTH:0] w_sum;
  logic signed [ACC_WIDTH:0] w_r;
  logic signed [ACC_WIDTH:0] w_relu;
  logic                      w_hi;
  logic                      w_lo;

  // One guard bit keeps the rounding add from wrapping at the top of range.
  assign w_ext = (ACC_WIDTH+1)'(acc_i);
  assign w_sum = w_ext + c_rnd;
  assign w_r   = w_sum >>> FRAC_SHIFT;

`ifdef CNN_RELU_EN
  assign w_relu = w_r[ACC_WIDTH] ? '0 : w_r;
`else
  assign w_relu = w_r;
`endif

  assign w_hi = (w_relu > c_max);
  assign w_lo = (w_relu < c_min);

  always_comb begin
    data_o = w_relu[OUT_WIDTH-1:0];
    sat_o  = 1'b0;
    if (w_hi) begin
      data_o = c_max[OUT_WIDTH-1:0];
      sat_o  = 1'b1;
    end else if (w_lo) begin
      data_o = c_min[OUT_WIDTH-1:0];
      sat_o  = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cnn_mac_acc_relu.sv
`default_nettype none
// ============================================================================
// Module   : cnn_mac_acc_relu
// Brief    : Per-pixel tap accumulator with bias, rescale, ReLU and saturation.
//            ReLU enabled by defining CNN_RELU_EN.
// Revision : 1.0
// ============================================================================
module cnn_mac_acc_relu
  import cnn_pkg::*;
#(
  parameter int PROD_WIDTH = PROD_WIDTH_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_TAPS   = 25,
  parameter int FRAC_SHIFT = 6
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         prod_valid,
  output logic                         prod_ready,
  input  logic signed [PROD_WIDTH-1:0] prod_data,
  input  logic                         prod_last,
  input  logic signed [OUT_WIDTH-1:0]  bias,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_sat,
  output logic                         tap_err
);

  localparam int             CNT_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [CNT_W-1:0] c_last_tap = CNT_W'(NUM_TAPS - 1);

  generate
    if (ACC_WIDTH < PROD_WIDTH + $clog2(NUM_TAPS) + 1) begin : g_acc_width_err
      $error("ACC_WIDTH too small for PROD_WIDTH and NUM_TAPS");
    end
    if (NUM_TAPS < 1 || FRAC_SHIFT < 1) begin : g_param_err
      $error("NUM_TAPS and FRAC_SHIFT must be >= 1");
    end
  endgenerate

  state_e                        state_q, state_d;
  logic                          prod_ready_q, prod_ready_d;
  logic                          out_valid_q, out_valid_d;
  logic [CNT_W-1:0]              tap_cnt_q, tap_cnt_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [OUT_WIDTH-1:0]   out_data_q, out_data_d;
  logic                          out_sat_q, out_sat_d;
  logic                          tap_err_q, tap_err_d;

  logic                          w_fire;
  logic                          w_last_tap;
  logic signed [ACC_WIDTH-1:0]   w_bias_ext;
  logic signed [ACC_WIDTH-1:0]   w_bias_sh;
  logic signed [ACC_WIDTH-1:0]   w_prod_ext;
  logic signed [OUT_WIDTH-1:0]   w_rs_data;
  logic                          w_rs_sat;

  assign w_fire     = prod_valid && prod_ready_q;
  assign w_last_tap = (tap_cnt_q == c_last_tap);
  assign w_bias_ext = ACC_WIDTH'(bias);
  assign w_bias_sh  = w_bias_ext <<< FRAC_SHIFT;
  assign w_prod_ext = ACC_WIDTH'(prod_data);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= ST_ACC;
    else           state_q <= state_d;
  end

  // The tap counter, not prod_last, decides where a window ends.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC:  if (w_fire && w_last_tap) state_d = ST_OUT;
      ST_OUT:  if (out_ready)            state_d = ST_ACC;
      default: state_d = ST_ACC;
    endcase
  end

  always_comb begin
    prod_ready_d = (state_d == ST_ACC);
    out_valid_d  = (state_d == ST_OUT);
  end

  always_comb begin
    acc_d      = acc_q;
    tap_cnt_d  = tap_cnt_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    tap_err_d  = w_fire && (prod_last != w_last_tap);
    if (w_fire) begin
      if (tap_cnt_q == '0) acc_d = w_bias_sh + w_prod_ext;
      else                 acc_d = acc_q + w_prod_ext;
      tap_cnt_d = w_last_tap ? '0 : tap_cnt_q + CNT_W'(1);
      if (w_last_tap) begin
        out_data_d = w_rs_data;
        out_sat_d  = w_rs_sat;
      end
    end
  end

  cnn_round_sat #(
    .ACC_WIDTH  (ACC_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_round_sat (
    .acc_i  (acc_d),
    .data_o (w_rs_data),
    .sat_o  (w_rs_sat)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      prod_ready_q <= 1'b0;
      out_valid_q  <= 1'b0;
      tap_cnt_q    <= '0;
      acc_q        <= '0;
      out_data_q   <= '0;
      out_sat_q    <= 1'b0;
      tap_err_q    <= 1'b0;
    end else begin
      prod_ready_q <= prod_ready_d;
      out_valid_q  <= out_valid_d;
      tap_cnt_q    <= tap_cnt_d;
      acc_q        <= acc_d;
      out_data_q   <= out_data_d;
      out_sat_q    <= out_sat_d;
      tap_err_q    <= tap_err_d;
    end
  end

  assign prod_ready = prod_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sat    = out_sat_q;
  assign tap_err    = tap_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cnn_mac_acc_relu.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_mac_acc_relu
// Brief    : Directed self-checking bench for cnn_mac_acc_relu (default params).
// Revision : 1.0
// ============================================================================
module tb_cnn_mac_acc_relu;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic               prod_valid = 1'b0;
  logic               prod_ready;
  logic signed [21:0] prod_data = '0;
  logic               prod_last = 1'b0;
  logic signed [13:0] bias = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [13:0] out_data;
  logic               out_sat;
  logic               tap_err;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;

  cnn_mac_acc_relu dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod_data  (prod_data),
    .prod_last  (prod_last),
    .bias       (bias),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .tap_err    (tap_err)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Presents one beat and returns #1 after the edge that accepted it.
  task automatic send(input int d, input bit last, input int b);
    int n;
    prod_valid = 1'b1;
    prod_data  = 22'(d);
    prod_last  = last;
    bias       = 14'(b);
    n = 0;
    while (prod_ready !== 1'b1 && n < 200) begin
      @(posedge ap_clk); #1;
      n++;
    end
    if (n >= 200) check("send_timeout", int'(prod_ready), 1);
    @(posedge ap_clk); #1;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    if (tap_err === 1'b1) err_pulses++;
  endtask

  task automatic window(input string tag, input int first, input int rest,
                        input int b, input int exp_d, input int exp_s);
    send(first, 1'b0, b);
    for (int i = 1; i < 24; i++) send(rest, 1'b0, b);
    send(rest, 1'b1, b);
    check({tag, "_valid"}, int'(out_valid), 1);
    check({tag, "_data"}, int'(out_data), exp_d);
    check({tag, "_sat"}, int'(out_sat), exp_s);
    @(posedge ap_clk); #1;
    check({tag, "_ready_next"}, int'(prod_ready), 1);
  endtask

  initial begin
    // Reset values
    #3;
    check("rst_ready", int'(prod_ready), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_sat", int'(out_sat), 0);
    check("rst_err", int'(tap_err), 0);
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    check("rst_ready_pre", int'(prod_ready), 0);
    @(posedge ap_clk); #1;
    check("ready_after_rst", int'(prod_ready), 1);

    // Basic accumulate
    err_pulses = 0;
    window("w64", 64, 64, 0, 25, 0);
    check("w64_no_err", err_pulses, 0);

    window("sat_hi", 1048576, 1048576, 0, 8191, 1);
`ifdef CNN_RELU_EN
    window("neg64", -64, -64, 0, 0, 0);
    window("sat_lo", -1048576, -1048576, 0, 0, 0);
`else
    window("neg64", -64, -64, 0, -25, 0);
    window("sat_lo", -1048576, -1048576, 0, -8192, 1);
`endif

    // Rounding
    window("rnd32", 32, 0, 0, 1, 0);
    window("rnd31", 31, 0, 0, 0, 0);
    window("bias3", 0, 0, 3, 3, 0);

    // Output backpressure
    out_ready = 1'b0;
    send(64, 1'b0, 0);
    for (int i = 1; i < 24; i++) send(64, 1'b0, 0);
    send(64, 1'b1, 0);
    prod_valid = 1'b1;
    prod_data  = 22'(64);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", int'(out_valid), 1);
      check("bp_data", int'(out_data), 25);
      check("bp_ready", int'(prod_ready), 0);
      @(posedge ap_clk); #1;
    end
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    check("bp_valid_drop", int'(out_valid), 0);
    send(64, 1'b0, 0);
    for (int i = 1; i < 24; i++) send(64, 1'b0, 0);
    send(64, 1'b1, 0);
    check("bp_resume_valid", int'(out_valid), 1);
    check("bp_resume_data", int'(out_data), 25);
    @(posedge ap_clk); #1;

    // Early prod_last
    err_pulses = 0;
    for (int i = 0; i < 9; i++) send(64, 1'b0, 0);
    send(64, 1'b1, 0);
    check("early_last_no_out", int'(out_valid), 0);
    for (int i = 10; i < 24; i++) send(64, 1'b0, 0);
    send(64, 1'b1, 0);
    check("early_last_valid", int'(out_valid), 1);
    check("early_last_data", int'(out_data), 25);
    check("early_last_pulses", err_pulses, 1);
    @(posedge ap_clk); #1;

    // Reset mid-window
    for (int i = 0; i < 10; i++) send(64, 1'b0, 0);
    #2 ap_rst_n = 1'b0;
    #1;
    check("mid_rst_ready", int'(prod_ready), 0);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_data", int'(out_data), 0);
    check("mid_rst_sat", int'(out_sat), 0);
    check("mid_rst_err", int'(tap_err), 0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    window("post_rst", 64, 64, 0, 25, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
